// File: rtl/sym_unfold_pipe.sv
// Symmetry unfold stage: folds signed lanes to |x| for a half-domain core and
// rebuilds f(x) from the in-order core results using a per-transaction mode.
module sym_unfold_pipe #(
  parameter int M     = 4,
  parameter int N     = 8,
  parameter int LANES = 4,
  parameter int DEPTH = 8,
  localparam int W    = M + N,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*W-1:0]   in_x,
  input  logic [1:0]           in_mode,
  output logic                 core_x_valid,
  input  logic                 core_x_ready,
  output logic [LANES*W-1:0]   core_x,
  input  logic                 core_y_valid,
  output logic                 core_y_ready,
  input  logic [LANES*W-1:0]   core_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   out_y,
  output logic [PW:0]          inflight,
  output logic                 err
);

  localparam int EW = LANES + LANES*W + 2;
  localparam logic [PW:0] CAP = (PW+1)'(DEPTH);
  localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W:0] ONE_X = (W+1)'(1 << N);

  logic [EW-1:0]         mem [DEPTH];
  logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]           count_reg;
  logic                  core_x_valid_reg, out_valid_reg, err_reg;
  logic [LANES*W-1:0]    core_x_reg, out_y_reg;
  logic [LANES*W-1:0]    fold_next, y_next;
  logic [LANES-1:0]      sign_next;
  logic [EW-1:0]         head;
  logic [LANES-1:0]      head_sign;
  logic [LANES*W-1:0]    head_x;
  logic [1:0]            head_mode;
  logic                  fifo_empty, push, pop, y_hs;

  assign fifo_empty   = (count_reg == '0);
  assign in_ready     = (count_reg < CAP) && (!core_x_valid_reg || core_x_ready);
  assign push         = in_valid && in_ready;
  assign core_y_ready = !out_valid_reg || out_ready;
  assign y_hs         = core_y_valid && core_y_ready;
  assign pop          = y_hs && !fifo_empty;

  assign head = mem[rd_ptr_reg];
  assign {head_sign, head_x, head_mode} = head;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [W-1:0] x_in, x_head, f;
      logic signed [W:0]   f_ext, x_ext, wide;

      assign x_in           = in_x[gi*W +: W];
      assign sign_next[gi]  = x_in[W-1];
      // The most negative code has no positive twin, so it folds to the maximum.
      assign fold_next[gi*W +: W] = !x_in[W-1] ? x_in : ((x_in == SMIN) ? SMAX : -x_in);

      assign x_head = head_x[gi*W +: W];
      assign f      = core_y[gi*W +: W];
      assign f_ext  = {f[W-1], f};
      assign x_ext  = {x_head[W-1], x_head};

      always_comb begin
        wide = f_ext;
        if (head_sign[gi]) begin
          case (head_mode)
            2'd1:    wide = ONE_X - f_ext;
            2'd2:    wide = f_ext + x_ext;
            2'd3:    wide = -f_ext;
            default: wide = f_ext;
          endcase
        end
      end

      assign y_next[gi*W +: W] = (wide[W] == wide[W-1]) ? wide[W-1:0] : (wide[W] ? SMIN : SMAX);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {sign_next, in_x, in_mode};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      core_x_valid_reg <= 1'b0;
      core_x_reg       <= '0;
      out_valid_reg    <= 1'b0;
      out_y_reg        <= '0;
      err_reg          <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: ;
      endcase

      if (push) begin
        core_x_valid_reg <= 1'b1;
        core_x_reg       <= fold_next;
      end else if (core_x_ready) begin
        core_x_valid_reg <= 1'b0;
      end

      if (pop) begin
        out_valid_reg <= 1'b1;
        out_y_reg     <= y_next;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end

      // A result with nothing outstanding is dropped and flagged until reset.
      if (core_y_valid && fifo_empty) err_reg <= 1'b1;
    end
  end

  assign core_x_valid = core_x_valid_reg;
  assign core_x       = core_x_reg;
  assign out_valid    = out_valid_reg;
  assign out_y        = out_y_reg;
  assign inflight     = count_reg;
  assign err          = err_reg;

endmodule

// File: tb/tb_sym_unfold_pipe.sv
// Scoreboard bench for sym_unfold_pipe: directed vectors, a simple echo core
// model, and monitors that pop expected operands/results as the DUT emits them.
module tb_sym_unfold_pipe;
  localparam int W  = 12;
  localparam int LW = 4 * W;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [LW-1:0] in_x = '0;
  logic [1:0] in_mode = 2'd0;
  logic core_x_valid;
  logic core_x_ready = 1'b1;
  logic [LW-1:0] core_x;
  logic core_y_valid = 1'b0;
  logic core_y_ready;
  logic [LW-1:0] core_y = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [LW-1:0] out_y;
  logic [3:0] inflight;
  logic err;

  sym_unfold_pipe #(.M(4), .N(8), .LANES(4), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_mode(in_mode),
    .core_x_valid(core_x_valid), .core_x_ready(core_x_ready), .core_x(core_x),
    .core_y_valid(core_y_valid), .core_y_ready(core_y_ready), .core_y(core_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .inflight(inflight), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [LW-1:0] exp_cx[$];
  logic [LW-1:0] exp_out[$];
  logic [LW-1:0] core_ret[$];
  int out_cycles[$];
  bit core_en = 1'b0;
  bit ovr_en = 1'b0;
  bit err_inj = 1'b0;
  logic [LW-1:0] ovr_val = '0;
  logic [LW-1:0] va, cxa, vb, cxb;
  logic [LW-1:0] ya[4];
  logic [LW-1:0] yb[4];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [LW-1:0] pack(int a, int b, int c, int d);
    logic [LW-1:0] p;
    p[0   +: W] = W'(a);
    p[W   +: W] = W'(b);
    p[2*W +: W] = W'(c);
    p[3*W +: W] = W'(d);
    return p;
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end else begin
      $display("ok   %s value=%h (t=%0t)", name, act, $time);
    end
  endtask

  // Echo core: returns each accepted operand (or an override) one cycle later, in order.
  initial begin : core_model
    logic xh, yh;
    logic [LW-1:0] xv;
    forever begin
      @(negedge clk);
      xh = rst_n && core_x_valid && core_x_ready;
      yh = rst_n && core_y_valid && core_y_ready;
      xv = core_x;
      if (xh) begin
        if (exp_cx.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL core_x_unexpected actual=%h required=none", xv);
        end else begin
          chk("core_x", xv, exp_cx.pop_front());
        end
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
        core_ret.delete();
      end else begin
        if (yh && core_ret.size() > 0) void'(core_ret.pop_front());
        if (xh) core_ret.push_back(ovr_en ? ovr_val : xv);
      end
      core_y_valid = err_inj || (core_en && core_ret.size() > 0);
      core_y = (core_ret.size() > 0) ? core_ret[0] : '0;
    end
  end

  initial begin : out_mon
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        out_cycles.push_back(cyc);
        if (exp_out.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_unexpected actual=%h required=none", out_y);
        end else begin
          chk("out_y", out_y, exp_out.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [LW-1:0] x, input logic [1:0] m,
                      input logic [LW-1:0] cx, input logic [LW-1:0] y);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_x = x;
    in_mode = m;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_cx.push_back(cx);
        exp_out.push_back(y);
        @(posedge clk);
        #1;
        break;
      end
      n++;
      if (n > 200) begin
        checks++;
        failures++;
        $display("FAIL send_timeout actual=in_ready_low required=accept");
        @(posedge clk);
        #1;
        break;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_out.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 500) begin
      failures++;
      $display("FAIL %s actual=pending=%0d required=pending=0", name, exp_out.size());
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int k;
    va  = pack(-384, 384, 0, -2048);
    cxa = pack(384, 384, 0, 2047);
    ya[0] = pack(384, 384, 0, 2047);
    ya[1] = pack(-128, 384, 0, -1791);
    ya[2] = pack(0, 384, 0, -1);
    ya[3] = pack(-384, 384, 0, -2047);
    vb  = pack(100, -100, -1, 2047);
    cxb = pack(100, 100, 1, 2047);
    yb[0] = pack(100, 100, 1, 2047);
    yb[1] = pack(100, 156, 255, 2047);
    yb[2] = pack(100, 0, 0, 2047);
    yb[3] = pack(100, -100, -1, 2047);

    // Reset state, observed before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_core_x_valid", core_x_valid, 0);
    chk("rst_core_x", core_x, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_err", err, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("idle_in_ready", in_ready, 1);

    // Sign reconstruction across all modes for two vectors.
    core_en = 1'b1;
    for (int m = 0; m < 4; m++) send(va, 2'(m), cxa, ya[m]);
    for (int m = 0; m < 4; m++) send(vb, 2'(m), cxb, yb[m]);
    in_valid = 1'b0;
    wait_drain("drain_modes");

    // Complement mode overflow saturates to the positive limit.
    ovr_val = pack(-2048, -2048, -2048, -2048);
    ovr_en = 1'b1;
    send(pack(-1, -1, -1, -1), 2'd1, pack(1, 1, 1, 1), pack(2047, 2047, 2047, 2047));
    in_valid = 1'b0;
    wait_drain("drain_sat");
    ovr_en = 1'b0;

    // Results withheld: the FIFO fills at eight and input stalls.
    core_en = 1'b0;
    k = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      in_x = (k % 2 == 1) ? vb : va;
      in_mode = 2'(k % 4);
      @(negedge clk);
      if (in_ready) begin
        exp_cx.push_back((k % 2 == 1) ? cxb : cxa);
        exp_out.push_back((k % 2 == 1) ? yb[k % 4] : ya[k % 4]);
        k++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("full_accepts", k, 8);
    chk("full_inflight", inflight, 8);
    chk("full_in_ready", in_ready, 0);
    core_en = 1'b1;
    wait_drain("drain_full");
    chk("drained_inflight", inflight, 0);

    // Streaming: one result per cycle once the pipe is primed.
    out_cycles.delete();
    for (int i = 0; i < 20; i++) begin
      if ((i / 4) % 2 == 1) send(vb, 2'(i % 4), cxb, yb[i % 4]);
      else                  send(va, 2'(i % 4), cxa, ya[i % 4]);
    end
    in_valid = 1'b0;
    wait_drain("drain_stream");
    chk("stream_count", out_cycles.size(), 20);
    if (out_cycles.size() == 20) chk("stream_span", out_cycles[19] - out_cycles[0], 19);

    // Stray core result with nothing in flight.
    chk("pre_err", err, 0);
    err_inj = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("err_no_out_valid", out_valid, 0);
    end
    chk("err_core_y_ready", core_y_ready, 1);
    err_inj = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("err_set", err, 1);
    chk("err_out_valid", out_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", err, 1);

    // Reset in the middle of traffic with a stalled output.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(va, 2'(i % 4), cxa, ya[i % 4]);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_inflight", inflight, 5);
    chk("mid_out_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_core_x_valid", core_x_valid, 0);
    chk("arst_core_x", core_x, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_y", out_y, 0);
    chk("arst_inflight", inflight, 0);
    chk("arst_err", err, 0);
    exp_out.delete();
    exp_cx.delete();
    core_en = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    core_en = 1'b1;
    send(vb, 2'd3, cxb, yb[3]);
    in_valid = 1'b0;
    wait_drain("drain_after_reset");
    chk("post_reset_inflight", inflight, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
